// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freeze with timeout FSM, and saturating stall/flush counters.
module hazard_stall_unit #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IFIDRs,
  input  logic [REG_W-1:0] IFIDRt,
  input  logic [REG_W-1:0] IDEXRt,
  input  logic             IDEXMemRead,
  input  logic             BranchTaken,
  input  logic             EXMEMMemAccess,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXFlush,
  output logic             EXMEMWrite,
  output logic             MEMWBBubble,
  output logic             MemTimeout,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

  state_t            state_reg, state_next, dec_state;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_timeout_reg;
  logic              mem_stall, load_use;
  logic              freeze, flush_act, stall_act;
  logic [1:0]        cnt_inc;

  assign mem_stall = EXMEMMemAccess & ~MemReady;
  assign load_use  = IDEXMemRead & (IDEXRt != '0) &
                     ((IDEXRt == IFIDRs) | (IDEXRt == IFIDRt));

  // While reset is held the pipeline is steered by the RUN decode.
  assign dec_state = reset ? RUN : state_reg;

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXWrite   = 1'b1;
    IDEXFlush   = 1'b0;
    EXMEMWrite  = 1'b1;
    MEMWBBubble = 1'b0;
    freeze      = 1'b0;
    flush_act   = 1'b0;
    stall_act   = 1'b0;
    if (dec_state == ERROR) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
    end else if (mem_stall) begin
      // Branch and load-use are frozen in place and re-evaluated after release.
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
      freeze      = 1'b1;
    end else if (BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      flush_act = 1'b1;
    end else if (load_use) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
      stall_act = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          if (wait_cnt_next == TIMEOUT_W) state_next = ERROR;
        end else begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      ERROR: ;
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= (state_next == ERROR);
    end
  end

  assign cnt_inc = {flush_act, freeze | stall_act};

  // Index 0 counts stall cycles, index 1 counts branch flushes; both saturate.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign StallCycles = g_cnt[0].cnt_reg;
  assign FlushCount  = g_cnt[1].cnt_reg;
  assign MemTimeout  = mem_timeout_reg;
  assign State       = state_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios then random cycles, two instances
// (16-bit and 2-bit counters) checked against a rule-level reference model.
module tb_hazard_stall_unit;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFIDRs, IFIDRt, IDEXRt;
  logic       IDEXMemRead, BranchTaken, EXMEMMemAccess, MemReady;

  wire [6:0]  ctrl_a, ctrl_b;
  wire [1:0]  st_a, st_b;
  wire        to_a, to_b;
  wire [15:0] sc_a, fc_a;
  wire [1:0]  sc_b, fc_b;

  int checks = 0;
  int passed = 0;

  // Reference model: error flag, length of the current memory-stall run, raw counts.
  bit m_err;
  int m_run, m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_W(5), .CNT_W(16), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IDEXRt(IDEXRt),
    .IDEXMemRead(IDEXMemRead), .BranchTaken(BranchTaken),
    .EXMEMMemAccess(EXMEMMemAccess), .MemReady(MemReady),
    .PCWrite(ctrl_a[6]), .IFIDWrite(ctrl_a[5]), .IFIDFlush(ctrl_a[4]),
    .IDEXWrite(ctrl_a[3]), .IDEXFlush(ctrl_a[2]), .EXMEMWrite(ctrl_a[1]),
    .MEMWBBubble(ctrl_a[0]), .MemTimeout(to_a), .State(st_a),
    .StallCycles(sc_a), .FlushCount(fc_a));

  hazard_stall_unit #(.REG_W(5), .CNT_W(2), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IDEXRt(IDEXRt),
    .IDEXMemRead(IDEXMemRead), .BranchTaken(BranchTaken),
    .EXMEMMemAccess(EXMEMMemAccess), .MemReady(MemReady),
    .PCWrite(ctrl_b[6]), .IFIDWrite(ctrl_b[5]), .IFIDFlush(ctrl_b[4]),
    .IDEXWrite(ctrl_b[3]), .IDEXFlush(ctrl_b[2]), .EXMEMWrite(ctrl_b[1]),
    .MEMWBBubble(ctrl_b[0]), .MemTimeout(to_b), .State(st_b),
    .StallCycles(sc_b), .FlushCount(fc_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit m_memstall();
    return EXMEMMemAccess && !MemReady;
  endfunction

  function automatic bit m_loaduse();
    return IDEXMemRead && (IDEXRt != 0) && (IDEXRt == IFIDRs || IDEXRt == IFIDRt);
  endfunction

  // Expected {PCWrite,IFIDWrite,IFIDFlush,IDEXWrite,IDEXFlush,EXMEMWrite,MEMWBBubble}
  function automatic logic [6:0] exp_ctrl();
    if (m_err && !reset)  return 7'b0000001;
    if (m_memstall())     return 7'b0000001;
    if (BranchTaken)      return 7'b1111110;
    if (m_loaduse())      return 7'b0001110;
    return 7'b1101010;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_all();
    logic [6:0]  ec;
    logic [1:0]  es;
    ec = exp_ctrl();
    es = m_err ? 2'd2 : ((m_run > 0) ? 2'd1 : 2'd0);
    chk("ctrl_a", 32'(ctrl_a), 32'(ec));
    chk("ctrl_b", 32'(ctrl_b), 32'(ec));
    chk("state_a", 32'(st_a), 32'(es));
    chk("state_b", 32'(st_b), 32'(es));
    chk("timeout_a", 32'(to_a), 32'(m_err));
    chk("timeout_b", 32'(to_b), 32'(m_err));
    chk("stall_a", 32'(sc_a), 32'(sat(m_stall, 65535)));
    chk("stall_b", 32'(sc_b), 32'(sat(m_stall, 3)));
    chk("flush_a", 32'(fc_a), 32'(sat(m_flush, 65535)));
    chk("flush_b", 32'(fc_b), 32'(sat(m_flush, 3)));
  endtask

  task automatic model_step();
    bit ms;
    ms = m_memstall();
    if (reset) begin
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end else if (!m_err) begin
      if (ms)               m_stall++;
      else if (BranchTaken) m_flush++;
      else if (m_loaduse()) m_stall++;
      if (ms) begin
        m_run++;
        if (m_run == TO) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] exrt, input bit mr, input bit br,
                     input bit acc, input bit rdy);
    reset = r; IFIDRs = rs; IFIDRt = rt; IDEXRt = exrt;
    IDEXMemRead = mr; BranchTaken = br; EXMEMMemAccess = acc; MemReady = rdy;
  endtask

  task automatic idle(input bit r);
    set(r, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    idle(1'b1);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cycle();                                       // reset held: RUN decode, cleared state
    idle(1'b0); cycle();

    // Load-use on Rs, then the bubble cycle, then Rt=0 (no hazard)
    set(0, 5'd5, 5'd7, 5'd5, 1, 0, 0, 1); cycle();
    idle(0); cycle();
    set(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1); cycle();
    set(0, 5'd9, 5'd6, 5'd6, 1, 0, 0, 1); cycle();  // hazard via Rt

    // Branch coincident with load-use: flush wins
    idle(1); cycle();
    set(0, 5'd5, 5'd7, 5'd5, 1, 1, 0, 1); cycle();
    idle(0); cycle();

    // Three-cycle memory wait, then release
    repeat (3) begin set(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0); cycle(); end
    set(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1); cycle();
    idle(0); cycle();

    // Branch frozen in EX during a wait, flushed once after release
    repeat (2) begin set(0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0); cycle(); end
    set(0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1); cycle();
    idle(0); cycle();

    // Timeout into ERROR, MemReady in ERROR has no effect, reset clears
    repeat (TO + 1) begin set(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0); cycle(); end
    set(0, 5'd5, 5'd7, 5'd5, 1, 1, 1, 1); cycle();
    idle(0); cycle();
    idle(1); cycle();
    idle(0); cycle();

    // Reset asserted in the second stall cycle, stall persists afterwards
    set(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0); cycle();
    set(1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0); cycle();
    repeat (2) begin set(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0); cycle(); end
    idle(0); cycle();

    // Five load-use stalls: narrow counter saturates at 3
    idle(1); cycle();
    repeat (5) begin
      set(0, 5'd4, 5'd8, 5'd4, 1, 0, 0, 1); cycle();
      idle(0); cycle();
    end

    // Randomized traffic with small register indices to provoke hazards
    repeat (400) begin
      set(($urandom_range(0, 39) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard and stall controller for the 5-stage CPU, the stall/flush counterpart of the forwarding path. It handles the RAW hazards that bypassing cannot resolve (load-use) and inserts one bubble for each. It also flushes the front end on taken branches and freezes the pipeline while data memory is not ready. A small FSM tracks memory-wait episodes, enforces a timeout, and keeps saturating performance counters.

## Interface
Parameters:
- REG_W, 5, register-address width
- CNT_W, 16, width of the performance counters
- TIMEOUT, 8, consecutive memory-stall cycles that trigger the error state (≥2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- IFIDRs  in  REG_W  Rs of the instruction in ID
- IFIDRt  in  REG_W  Rt of the instruction in ID
- IDEXRt  in  REG_W  destination of the load in EX
- IDEXMemRead  in  1  instruction in EX is a load
- BranchTaken  in  1  branch resolved taken in EX
- EXMEMMemAccess  in  1  instruction in MEM accesses data memory
- MemReady  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC may update
- IFIDWrite  out  1  IF/ID may load
- IFIDFlush  out  1  IF/ID loads a NOP
- IDEXWrite  out  1  ID/EX may load
- IDEXFlush  out  1  ID/EX loads a bubble (control bits zeroed)
- EXMEMWrite  out  1  EX/MEM may load
- MEMWBBubble  out  1  MEM/WB loads a bubble
- MemTimeout  out  1  sticky error flag
- State  out  2  FSM state: RUN=0, MEM_WAIT=1, ERROR=2
- StallCycles  out  CNT_W  saturating count of stall cycles
- FlushCount  out  CNT_W  saturating count of branch flushes

## Operation
- Combinational terms:
  - memStall = EXMEMMemAccess & ~MemReady
  - loadUse = IDEXMemRead & (IDEXRt≠0) & (IDEXRt==IFIDRs | IDEXRt==IFIDRt)
- Default decode in RUN and MEM_WAIT: all *Write=1 and all flush/bubble outputs 0.
- Decode priority, highest first:
  1. ERROR: every *Write=0 and MEMWBBubble=1.
  2. memStall (freeze): PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0 and MEMWBBubble=1. Branch and load-use decode are suppressed because their instructions are frozen and are re-evaluated after release.
  3. BranchTaken: IFIDFlush=1 and IDEXFlush=1, with PC/IF/ID writes kept enabled. A simultaneous loadUse is ignored because the dependent instruction is flushed.
  4. loadUse: PCWrite=0, IFIDWrite=0, IDEXFlush=1. This lasts one cycle because the bubble clears IDEXMemRead.
- FSM and wait counter (waitCnt, internal, width clog2(TIMEOUT+1)):
  - RUN: if memStall, go to MEM_WAIT with waitCnt=1.
  - MEM_WAIT:
    - If memStall, waitCnt+1. When waitCnt+1==TIMEOUT, go to ERROR.
    - If not memStall, go to RUN with waitCnt=0.
  - ERROR: absorbing; only reset leaves it. MemTimeout=1 while in ERROR.
- Counters (saturate at all-ones and never wrap; hold in ERROR):
  - StallCycles +1 on each cycle with freeze or a load-use stall.
  - FlushCount +1 on each cycle where branch decode is acted on.

## Timing
- Control outputs are combinational from State and the inputs, with zero latency, so the pipeline registers see them before the same rising edge.
- State, waitCnt, MemTimeout and the counters update on the rising clk edge.
- Reset (any cycle, including mid-wait or in ERROR):
  - Next edge: State=RUN, waitCnt=0, MemTimeout=0, StallCycles=0, FlushCount=0.
  - While reset is high, control outputs follow the RUN decode of the current inputs.
  - Counters do not increment on the reset edge.
- Memory stall of N cycles (MemReady low for N cycles, N<TIMEOUT) gives N freeze cycles. Release happens in the cycle MemReady=1, when EX/MEM advances.
- TIMEOUT consecutive stall cycles put the FSM in ERROR starting at cycle TIMEOUT+1. MemReady rising in that cycle has no effect.
- A branch frozen in EX during MEM_WAIT is flushed in the first cycle after release, and FlushCount increments once.

## Test plan
- Load-use: IDEXMemRead=1, IDEXRt=5, IFIDRs=5 for one cycle → PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle (IDEXMemRead=0) all defaults; StallCycles=1. Repeat with IDEXRt=0 → no stall.
- Branch with load-use: BranchTaken=1, loadUse=1 in the same cycle → IFIDFlush=1, IDEXFlush=1, PCWrite=1; FlushCount=1, StallCycles=0.
- Memory wait: EXMEMMemAccess=1, MemReady=0 for 3 cycles then 1 → 3 freeze cycles (EXMEMWrite=0, MEMWBBubble=1); State 1 during the wait, 0 after release; StallCycles=3.
- Timeout: TIMEOUT=4, MemReady held 0 → State=2 and MemTimeout=1 from cycle 5; asserting MemReady keeps ERROR with all writes 0; reset → State=0 and counters 0.
- Reset mid-wait: reset asserted in the 2nd stall cycle → next cycle State=0, StallCycles=0; with memStall still high, re-entry to MEM_WAIT gives waitCnt=1.
- Saturation: CNT_W=2, 5 load-use stalls → StallCycles=3 (no wrap).
